// File: rtl/hci_package.sv
// Shared HCI interconnect types: runtime control word and arbitration policy codes.
package hci_package;

  localparam logic [1:0] HCI_ARB_PRIO = 2'b00;
  localparam logic [1:0] HCI_ARB_RR   = 2'b01;

  localparam int unsigned HCI_STALL_W = 8;

  typedef struct packed {
    logic [1:0] arb_policy;
    logic       hwpe_prio;
    logic [7:0] low_prio_max_stall;
  } hci_interconnect_ctrl_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } hci_port_e;

endpackage

// File: rtl/hci_arbiter_stall_counter.sv
// Counts consecutive cycles the low-priority port waits without a handshake; saturates at 255.
module hci_arbiter_stall_counter
  import hci_package::*;
(
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   clear,
  input  logic                   req,
  input  logic                   hs,
  output logic [HCI_STALL_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_ni || clear) begin
      count <= '0;
    end else if (!req || hs) begin
      count <= '0;
    end else if (count != {HCI_STALL_W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hci_prio_arbiter.sv
// Two-port arbiter (A = HWPE, B = core) onto one memory port, with fixed-priority
// plus starvation override or round-robin selection, and one-cycle response routing.
module hci_prio_arbiter
  import hci_package::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned BW = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  hci_interconnect_ctrl_t ctrl_i,

  input  logic                   a_req_i,
  output logic                   a_gnt_o,
  input  logic [AW-1:0]          a_add_i,
  input  logic                   a_wen_i,
  input  logic [DW-1:0]          a_data_i,
  input  logic [DW/BW-1:0]       a_be_i,
  output logic [DW-1:0]          a_r_data_o,
  output logic                   a_r_valid_o,

  input  logic                   b_req_i,
  output logic                   b_gnt_o,
  input  logic [AW-1:0]          b_add_i,
  input  logic                   b_wen_i,
  input  logic [DW-1:0]          b_data_i,
  input  logic [DW/BW-1:0]       b_be_i,
  output logic [DW-1:0]          b_r_data_o,
  output logic                   b_r_valid_o,

  output logic                   m_req_o,
  input  logic                   m_gnt_i,
  output logic [AW-1:0]          m_add_o,
  output logic                   m_wen_o,
  output logic [DW-1:0]          m_data_o,
  output logic [DW/BW-1:0]       m_be_o,
  input  logic [DW-1:0]          m_r_data_i,
  input  logic                   m_r_valid_i
);

  // Handshake on every port is req & gnt; gnt is only offered to the current
  // winner, and the memory answers exactly one cycle after its handshake.

  hci_port_e              hi_port;
  hci_port_e              lo_port;
  hci_port_e              winner;
  hci_port_e              rr_ptr;
  hci_port_e              owner;
  logic                   lo_req;
  logic                   lo_hs;
  logic                   hs;
  logic                   starve;
  logic [HCI_STALL_W-1:0] stall_cnt;

  assign hi_port = ctrl_i.hwpe_prio ? PORT_A : PORT_B;
  assign lo_port = ctrl_i.hwpe_prio ? PORT_B : PORT_A;
  assign lo_req  = (lo_port == PORT_A) ? a_req_i : b_req_i;

  assign starve = (ctrl_i.low_prio_max_stall != '0) &&
                  (stall_cnt >= ctrl_i.low_prio_max_stall);

  // Contention is the only case where policy matters; a lone requester always wins.
  always_comb begin
    winner = PORT_A;
    if (a_req_i && !b_req_i) begin
      winner = PORT_A;
    end else if (b_req_i && !a_req_i) begin
      winner = PORT_B;
    end else if (a_req_i && b_req_i) begin
      if (ctrl_i.arb_policy == HCI_ARB_RR) begin
        winner = rr_ptr;
      end else begin
        winner = starve ? lo_port : hi_port;
      end
    end
  end

  assign m_req_o  = a_req_i | b_req_i;
  assign m_add_o  = (winner == PORT_B) ? b_add_i  : a_add_i;
  assign m_wen_o  = (winner == PORT_B) ? b_wen_i  : a_wen_i;
  assign m_data_o = (winner == PORT_B) ? b_data_i : a_data_i;
  assign m_be_o   = (winner == PORT_B) ? b_be_i   : a_be_i;

  assign a_gnt_o = a_req_i && m_gnt_i && (winner == PORT_A);
  assign b_gnt_o = b_req_i && m_gnt_i && (winner == PORT_B);

  assign hs    = m_req_o & m_gnt_i;
  assign lo_hs = (lo_port == PORT_A) ? a_gnt_o : b_gnt_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rr_ptr <= PORT_A;
      owner  <= PORT_A;
    end else if (hs) begin
      owner  <= winner;
      rr_ptr <= (winner == PORT_A) ? PORT_B : PORT_A;
    end
  end

  hci_arbiter_stall_counter u_stall (
    .clk    (clk_i),
    .rst_ni (rst_ni),
    .clear  (clear_i),
    .req    (lo_req),
    .hs     (lo_hs),
    .count  (stall_cnt)
  );

  // Owner still holds the pre-clear value during a clear cycle, so a response
  // landing then reaches the port that issued it.
  assign a_r_valid_o = m_r_valid_i && (owner == PORT_A);
  assign b_r_valid_o = m_r_valid_i && (owner == PORT_B);
  assign a_r_data_o  = m_r_data_i;
  assign b_r_data_o  = m_r_data_i;

endmodule

// File: tb/tb_hci_prio_arbiter.sv
// Self-checking bench for hci_prio_arbiter: per-cycle behavioural model plus directed literal checks.
module tb_hci_prio_arbiter;
  import hci_package::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BW  = 8;
  localparam int BEW = DW / BW;

  logic                   clk;
  logic                   rst_ni;
  logic                   clear_i;
  hci_interconnect_ctrl_t ctrl_i;
  logic                   a_req_i, b_req_i;
  logic                   a_gnt_o, b_gnt_o;
  logic [AW-1:0]          a_add_i, b_add_i;
  logic                   a_wen_i, b_wen_i;
  logic [DW-1:0]          a_data_i, b_data_i;
  logic [BEW-1:0]         a_be_i, b_be_i;
  logic [DW-1:0]          a_r_data_o, b_r_data_o;
  logic                   a_r_valid_o, b_r_valid_o;
  logic                   m_req_o, m_gnt_i;
  logic [AW-1:0]          m_add_o;
  logic                   m_wen_o;
  logic [DW-1:0]          m_data_o;
  logic [BEW-1:0]         m_be_o;
  logic [DW-1:0]          m_r_data_i;
  logic                   m_r_valid_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: ports as ints, 0 = A, 1 = B.
  int mdl_cnt   = 0;
  int mdl_ptr   = 0;
  int mdl_owner = 0;
  logic resp_due = 1'b0;

  hci_prio_arbiter #(.DW(DW), .AW(AW), .BW(BW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .ctrl_i      (ctrl_i),
    .a_req_i     (a_req_i),
    .a_gnt_o     (a_gnt_o),
    .a_add_i     (a_add_i),
    .a_wen_i     (a_wen_i),
    .a_data_i    (a_data_i),
    .a_be_i      (a_be_i),
    .a_r_data_o  (a_r_data_o),
    .a_r_valid_o (a_r_valid_o),
    .b_req_i     (b_req_i),
    .b_gnt_o     (b_gnt_o),
    .b_add_i     (b_add_i),
    .b_wen_i     (b_wen_i),
    .b_data_i    (b_data_i),
    .b_be_i      (b_be_i),
    .b_r_data_o  (b_r_data_o),
    .b_r_valid_o (b_r_valid_o),
    .m_req_o     (m_req_o),
    .m_gnt_i     (m_gnt_i),
    .m_add_o     (m_add_o),
    .m_wen_o     (m_wen_o),
    .m_data_o    (m_data_o),
    .m_be_o      (m_be_o),
    .m_r_data_i  (m_r_data_i),
    .m_r_valid_i (m_r_valid_i)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Memory stub: answers one cycle after each handshake the model saw.
  always @(posedge clk) begin
    #1;
    m_r_valid_i = resp_due;
    m_r_data_i  = $urandom;
  end

  function automatic int model_winner();
    int hi;
    if (!a_req_i && !b_req_i) return -1;
    if (a_req_i != b_req_i) return a_req_i ? 0 : 1;
    hi = ctrl_i.hwpe_prio ? 0 : 1;
    if (ctrl_i.arb_policy == 2'b01) return mdl_ptr;
    if (ctrl_i.low_prio_max_stall != 8'd0 && mdl_cnt >= int'(ctrl_i.low_prio_max_stall)) return 1 - hi;
    return hi;
  endfunction

  // compare process: check every cycle, then advance the model
  always @(negedge clk) begin
    int   w;
    int   lo;
    logic lo_req;
    logic lo_hs;
    logic exp_hs;
    w      = model_winner();
    exp_hs = (a_req_i | b_req_i) & m_gnt_i;
    chk("m_req", m_req_o, a_req_i | b_req_i);
    chk("a_gnt", a_gnt_o, (w == 0) && m_gnt_i);
    chk("b_gnt", b_gnt_o, (w == 1) && m_gnt_i);
    if (w >= 0) begin
      chk("m_add",  m_add_o,  (w == 0) ? a_add_i  : b_add_i);
      chk("m_wen",  m_wen_o,  (w == 0) ? a_wen_i  : b_wen_i);
      chk("m_data", m_data_o, (w == 0) ? a_data_i : b_data_i);
      chk("m_be",   m_be_o,   (w == 0) ? a_be_i   : b_be_i);
    end
    chk("a_r_valid", a_r_valid_o, m_r_valid_i && (mdl_owner == 0));
    chk("b_r_valid", b_r_valid_o, m_r_valid_i && (mdl_owner == 1));
    chk("a_r_data", a_r_data_o, m_r_data_i);
    chk("b_r_data", b_r_data_o, m_r_data_i);
    chk("stall_cnt", dut.u_stall.count, mdl_cnt);

    lo     = ctrl_i.hwpe_prio ? 1 : 0;
    lo_req = (lo == 0) ? a_req_i : b_req_i;
    lo_hs  = (w == lo) && m_gnt_i;
    if (!rst_ni || clear_i) begin
      mdl_cnt   = 0;
      mdl_ptr   = 0;
      mdl_owner = 0;
    end else begin
      if (!lo_req || lo_hs) mdl_cnt = 0;
      else if (mdl_cnt < 255) mdl_cnt++;
      if (w >= 0 && m_gnt_i) begin
        mdl_owner = w;
        mdl_ptr   = 1 - w;
      end
    end
    resp_due = exp_hs;
  end

  // driver tasks
  task automatic drive(input logic a, input logic b, input logic g);
    a_req_i  = a;
    b_req_i  = b;
    m_gnt_i  = g;
    clear_i  = 1'b0;
    a_add_i  = $urandom;
    b_add_i  = $urandom;
    a_wen_i  = 1'($urandom_range(0, 1));
    b_wen_i  = 1'($urandom_range(0, 1));
    a_data_i = $urandom;
    b_data_i = $urandom;
    a_be_i   = BEW'($urandom_range(0, (1 << BEW) - 1));
    b_be_i   = BEW'($urandom_range(0, (1 << BEW) - 1));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [1:0] pol, input logic hp, input logic [7:0] mx);
    ctrl_i.arb_policy         = pol;
    ctrl_i.hwpe_prio          = hp;
    ctrl_i.low_prio_max_stall = mx;
  endtask

  task automatic clear_cycle();
    drive(1'b0, 1'b0, 1'b0);
    clear_i = 1'b1;
    next_cycle();
    clear_i = 1'b0;
  endtask

  logic [5:0] rr_pat;

  initial begin
    rst_ni      = 1'b0;
    m_r_valid_i = 1'b0;
    m_r_data_i  = '0;
    set_ctrl(HCI_ARB_PRIO, 1'b1, 8'd0);
    drive(1'b0, 1'b0, 1'b0);

    // reset: nothing asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_a_gnt", a_gnt_o, 1'b0);
      chk("rst_b_gnt", b_gnt_o, 1'b0);
      chk("rst_m_req", m_req_o, 1'b0);
      chk("rst_rvalid", {a_r_valid_o, b_r_valid_o}, 2'b00);
      next_cycle();
    end
    rst_ni = 1'b1;
    next_cycle();

    // fixed priority, A high, no override: A every cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("fp_a_gnt", a_gnt_o, 1'b1);
      chk("fp_b_gnt", b_gnt_o, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    next_cycle();

    // starvation override at max_stall = 3: B on the 4th cycle, then A
    set_ctrl(HCI_ARB_PRIO, 1'b1, 8'd3);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("starve_b_gnt", b_gnt_o, i == 3);
      chk("starve_a_gnt", a_gnt_o, i != 3);
      if (i == 4) chk("starve_cnt_back0", dut.u_stall.count, 8'd0);
      next_cycle();
    end

    // B high priority: B wins contention
    set_ctrl(HCI_ARB_PRIO, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("bprio_b_gnt", b_gnt_o, 1'b1);
    next_cycle();

    // round-robin from pointer A: A,B,A,B,A,B
    clear_cycle();
    set_ctrl(HCI_ARB_RR, 1'b1, 8'd0);
    rr_pat = 6'b101010;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("rr_b_gnt", b_gnt_o, rr_pat[i]);
      chk("rr_a_gnt", a_gnt_o, !rr_pat[i]);
      next_cycle();
    end

    // response routing: A read at n, B write at n+1
    set_ctrl(HCI_ARB_PRIO, 1'b1, 8'd0);
    drive(1'b1, 1'b0, 1'b1);
    a_wen_i = 1'b1;
    next_cycle();
    drive(1'b0, 1'b1, 1'b1);
    b_wen_i = 1'b0;
    @(negedge clk);
    chk("route_n1_a", a_r_valid_o, 1'b1);
    chk("route_n1_b", b_r_valid_o, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("route_n2_a", a_r_valid_o, 1'b0);
    chk("route_n2_b", b_r_valid_o, 1'b1);
    next_cycle();

    // response in a clear cycle still goes to the pre-clear owner (B)
    drive(1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0);
    clear_i = 1'b1;
    @(negedge clk);
    chk("clr_route_b", b_r_valid_o, 1'b1);
    next_cycle();
    clear_i = 1'b0;

    // no memory grant for 300 cycles: counter saturates, no grants
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (a_gnt_o || b_gnt_o) chk("stall_no_gnt", {a_gnt_o, b_gnt_o}, 2'b00);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_sat", dut.u_stall.count, 8'd255);
    next_cycle();

    // clear after pointer moved to B: next contention goes to A
    clear_cycle();
    set_ctrl(HCI_ARB_RR, 1'b1, 8'd0);
    drive(1'b1, 1'b1, 1'b1);
    next_cycle();
    clear_cycle();
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("clr_rr_a_gnt", a_gnt_o, 1'b1);
    chk("clr_cnt", dut.u_stall.count, 8'd0);
    next_cycle();

    // mixed traffic across policies, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        set_ctrl(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 4)));
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 40) == 0) clear_i = 1'b1;
      next_cycle();
    end

    drive(1'b0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hci_prio_arbiter.md
HCI_PRIO_ARBITER -- requirements
Module: hci_prio_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32: data width.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter BW, default 8: byte width; byte-enable width = DW/BW.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 clear_i  in  1  synchronous soft clear of all state.
REQ-007 ctrl_i  in  hci_interconnect_ctrl_t  fields arb_policy, hwpe_prio, low_prio_max_stall.
REQ-008 a_req_i / b_req_i  in  1  request; port A = HWPE, port B = core.
REQ-009 a_gnt_o / b_gnt_o  out  1  grant (handshake = req & gnt).
REQ-010 a_add_i / b_add_i  in  AW  address.
REQ-011 a_wen_i / b_wen_i  in  1  1 = read, 0 = write.
REQ-012 a_data_i / b_data_i  in  DW  write data.
REQ-013 a_be_i / b_be_i  in  DW/BW  byte enables.
REQ-014 a_r_data_o / b_r_data_o  out  DW  response data.
REQ-015 a_r_valid_o / b_r_valid_o  out  1  response valid.
REQ-016 m_req_o, m_add_o, m_wen_o, m_data_o, m_be_o  out  1/AW/1/DW/DW/BW  request to shared memory side.
REQ-017 m_gnt_i, m_r_data_i, m_r_valid_i  in  1/DW/1  memory grant and response (fixed 1-cycle latency after handshake).

Function
REQ-018 m_req_o SHALL equal a_req_i | b_req_i; winner SHALL be selected combinationally in the same cycle.
REQ-019 m_add_o/m_wen_o/m_data_o/m_be_o SHALL carry the winner's fields; only the winner's gnt SHALL follow m_gnt_i, the loser's gnt SHALL be 0.
REQ-020 High-priority port SHALL be A when hwpe_prio=1, else B; the other is low-priority.
REQ-021 arb_policy 2'b00, 2'b10, 2'b11: fixed priority; high-prio wins when both request.
REQ-022 arb_policy 2'b01: round-robin; 1-bit rr pointer names preferred port; on each handshake pointer SHALL move to the port not granted.
REQ-023 Single requester SHALL always win regardless of policy or pointer.
REQ-024 Stall counter (8 bit) SHALL increment when low-prio req=1 and no low-prio handshake, saturating at 255.
REQ-025 Stall counter SHALL reset to 0 on low-prio handshake, or when low-prio req=0.
REQ-026 Under fixed priority, when low_prio_max_stall != 0 and counter >= low_prio_max_stall, low-prio SHALL win.
REQ-027 low_prio_max_stall = 0 SHALL disable starvation override.
REQ-028 Counter SHALL not affect winner under round-robin but SHALL keep counting.
REQ-029 On each handshake, owner register SHALL capture winner; next cycle m_r_valid_i SHALL route to owner's r_valid_o, other r_valid_o = 0.
REQ-030 a_r_data_o and b_r_data_o SHALL both be driven with m_r_data_i.
REQ-031 Back-to-back handshakes SHALL be supported every cycle with correct response routing.
REQ-032 ctrl_i SHALL be used unregistered; changes take effect same cycle; counter value is retained across ctrl changes.
REQ-033 m_gnt_i=0 SHALL hold winner selection stable only by inputs; no state changes except stall counter.

Reset
REQ-034 rst_ni=0 at clock edge: stall counter 0, rr pointer = A, owner = A.
REQ-035 During and after reset with no requests: all gnt 0, m_req_o 0, r_valid 0.
REQ-036 clear_i=1 SHALL have identical effect to reset; rst_ni takes precedence; response due in the cleared cycle SHALL still route to pre-clear owner.

Structure
REQ-037 Localparams HCI_ARB_PRIO = 2'b00 and HCI_ARB_RR = 2'b01 SHALL be added to hci_package; hci_interconnect_ctrl_t reused unchanged.
REQ-038 Stall counter SHALL be a sub-module hci_arbiter_stall_counter (inputs req, hs, clear; output 8-bit count).

Verification
REQ-039 Fixed prio, hwpe_prio=1, both req 4 cycles, m_gnt_i=1, max_stall=0 -> a_gnt_o=1 all 4 cycles, b_gnt_o=0.
REQ-040 Fixed prio, hwpe_prio=1, max_stall=3, both req continuously -> b granted on 4th cycle, counter returns 0, A granted next cycle.
REQ-041 arb_policy=01, both req 6 cycles -> grants alternate A,B,A,B,A,B.
REQ-042 A read hs cycle n, B write hs cycle n+1, m_r_valid_i 1 at n+1,n+2 -> a_r_valid_o at n+1, b_r_valid_o at n+2.
REQ-043 m_gnt_i=0 for 300 cycles with B low-prio requesting -> counter saturates at 255, no gnt asserted.
REQ-044 clear_i pulse after rr pointer moved to B -> next contention granted to A, counter 0.
